// File: rtl/ahb_spi_bridge_slave.sv
// AHB-Lite slave front end of the AHB-to-SPI bridge: pushes command words to the Tx FIFO.
// Optional Rx read timeout is enabled by defining AHB_SPI_RD_TIMEOUT_EN.
module ahb_spi_bridge_slave #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 32,
    parameter int RD_TIMEOUT = 255,
    localparam int CMD_W     = 1 + ADDR_W + DATA_W
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic              HSEL,
    input  logic [ADDR_W-1:0] HADDR,
    input  logic [1:0]        HTRANS,
    input  logic              HWRITE,
    input  logic [2:0]        HSIZE,
    input  logic [2:0]        HBURST,
    input  logic [DATA_W-1:0] HWDATA,
    input  logic              HREADY,
    output logic              HREADYOUT,
    output logic              HRESP,
    output logic [DATA_W-1:0] HRDATA,
    output logic [CMD_W-1:0]  tx_data,
    output logic              tx_wr_en,
    input  logic              tx_full,
    input  logic [DATA_W-1:0] rx_data,
    output logic              rx_rd_en,
    input  logic              rx_empty
);

    localparam int LANE_W = $clog2(DATA_W / 8);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WDATA = 3'd1;
    localparam logic [2:0] S_RCMD  = 3'd2;
    localparam logic [2:0] S_RWAIT = 3'd3;
    localparam logic [2:0] S_RDATA = 3'd4;
    localparam logic [2:0] S_ERR1  = 3'd5;
    localparam logic [2:0] S_ERR2  = 3'd6;

    logic [2:0]        state_q;
    logic [2:0]        state_d;
    logic [ADDR_W-1:0] addr_q;
    logic              write_q;
    logic [2:0]        size_q;
    logic [DATA_W-1:0] hrdata_q;

    logic              accept;
    logic              done;
    logic              load;
    logic [7:0]        sz_bytes;
    logic [LANE_W-1:0] align_m;
    logic              illegal;
    logic [2:0]        tgt;
    logic [DATA_W-1:0] wdata_sh;
    logic [DATA_W-1:0] wdata;
    logic              to_hit;
    logic              unused_ok;

    // Byte-enable style mask covering the low (1<<sz) bytes of the bus.
    function automatic logic [DATA_W-1:0] size_mask(input logic [2:0] sz);
        logic [DATA_W-1:0] m;
        m = '0;
        for (int b = 0; b < DATA_W / 8; b++) begin
            if (b < (1 << sz)) begin
                m[8*b +: 8] = 8'hFF;
            end
        end
        return m;
    endfunction

    assign unused_ok = ^{HBURST, HTRANS[0]};

    // Address-phase qualification and legality of the requested access.
    assign accept   = HSEL & HREADY & HTRANS[1];
    assign sz_bytes = 8'd1 << HSIZE;
    assign align_m  = sz_bytes[LANE_W-1:0] - LANE_W'(1);
    assign illegal  = (sz_bytes > 8'(DATA_W / 8)) |
                      (|(HADDR[LANE_W-1:0] & align_m));

    // Target state for a freshly accepted transfer.
    always_comb begin
        tgt = S_RCMD;
        if (illegal) begin
            tgt = S_ERR1;
        end else if (HWRITE) begin
            tgt = S_WDATA;
        end
    end

    // Data phase completes this cycle, so a new address phase may load.
    always_comb begin
        done = 1'b1;
        case (state_q)
            S_WDATA: done = ~tx_full;
            S_RCMD:  done = 1'b0;
            S_RWAIT: done = 1'b0;
            S_ERR1:  done = 1'b0;
            default: done = 1'b1;
        endcase
    end

    assign load = done & accept;

    // Read-wait timeout, only built when the feature is enabled.
`ifdef AHB_SPI_RD_TIMEOUT_EN
    localparam int CNT_W = $clog2(RD_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(RD_TIMEOUT - 1);

    logic [CNT_W-1:0] to_cnt;

    // Count RWAIT cycles; zero on entry and whenever outside RWAIT.
    always_ff @(posedge HCLK) begin
        if (HRESET || state_q != S_RWAIT) begin
            to_cnt <= '0;
        end else if (to_cnt != TO_LAST) begin
            to_cnt <= to_cnt + CNT_W'(1);
        end
    end

    assign to_hit = rx_empty & (to_cnt == TO_LAST);
`else
    localparam int unused_rd_to = RD_TIMEOUT;

    assign to_hit = 1'b0;
`endif

    // Next-state logic; completing states chain straight into the next transfer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_WDATA, S_RDATA, S_ERR2: begin
                if (done) begin
                    state_d = accept ? tgt : S_IDLE;
                end
            end
            S_RCMD: begin
                if (!tx_full) begin
                    state_d = S_RWAIT;
                end
            end
            S_RWAIT: begin
                if (!rx_empty) begin
                    state_d = S_RDATA;
                end else if (to_hit) begin
                    state_d = S_ERR1;
                end
            end
            S_ERR1:  state_d = S_ERR2;
            default: state_d = S_IDLE;
        endcase
    end

    // State and address-phase registers.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            write_q <= 1'b0;
            size_q  <= '0;
        end else begin
            state_q <= state_d;
            if (load) begin
                addr_q  <= HADDR;
                write_q <= HWRITE;
                size_q  <= HSIZE;
            end
        end
    end

    // Read data capture; holds until the next read pops the Rx FIFO.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            hrdata_q <= '0;
        end else if (rx_rd_en) begin
            hrdata_q <= rx_data & size_mask(size_q);
        end
    end

    assign wdata_sh = HWDATA >> {addr_q[LANE_W-1:0], 3'b000};
    assign wdata    = wdata_sh & size_mask(size_q);

    // FIFO command word, selected by state.
    always_comb begin
        tx_data = '0;
        case (state_q)
            S_WDATA: tx_data = {write_q, addr_q, wdata};
            S_RCMD:  tx_data = {1'b0, addr_q, {DATA_W{1'b0}}};
            default: tx_data = '0;
        endcase
    end

    assign tx_wr_en = ~HRESET & ~tx_full &
                      ((state_q == S_WDATA) | (state_q == S_RCMD));
    assign rx_rd_en = ~HRESET & ~rx_empty & (state_q == S_RWAIT);

    assign HREADYOUT = HRESET | done;
    assign HRESP     = ~HRESET & ((state_q == S_ERR1) | (state_q == S_ERR2));
    assign HRDATA    = hrdata_q;

endmodule

// File: tb/tb_ahb_spi_bridge_slave.sv
// Directed bench for ahb_spi_bridge_slave.
// Single-slave bus: HREADY is looped back from HREADYOUT.
module tb_ahb_spi_bridge_slave;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        HSEL;
    logic [7:0]  HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        HREADYOUT;
    logic        HRESP;
    logic [31:0] HRDATA;
    logic [40:0] tx_data;
    logic        tx_wr_en;
    logic        tx_full;
    logic [31:0] rx_data;
    logic        rx_rd_en;
    logic        rx_empty;

    int n_cmp = 0;
    int n_bad = 0;
    int push_cnt = 0;
    int pop_cnt = 0;
    int p0;
    int q0;

    assign HREADY = HREADYOUT;

    ahb_spi_bridge_slave #(
        .ADDR_W(8),
        .DATA_W(32),
        .RD_TIMEOUT(8)
    ) dut (
        .HCLK(HCLK),
        .HRESET(HRESET),
        .HSEL(HSEL),
        .HADDR(HADDR),
        .HTRANS(HTRANS),
        .HWRITE(HWRITE),
        .HSIZE(HSIZE),
        .HBURST(HBURST),
        .HWDATA(HWDATA),
        .HREADY(HREADY),
        .HREADYOUT(HREADYOUT),
        .HRESP(HRESP),
        .HRDATA(HRDATA),
        .tx_data(tx_data),
        .tx_wr_en(tx_wr_en),
        .tx_full(tx_full),
        .rx_data(rx_data),
        .rx_rd_en(rx_rd_en),
        .rx_empty(rx_empty)
    );

    always #5 HCLK = ~HCLK;

    // Count FIFO pushes and pops as they happen on the clock edge.
    always @(posedge HCLK) begin
        if (tx_wr_en) push_cnt <= push_cnt + 1;
        if (rx_rd_en) pop_cnt <= pop_cnt + 1;
    end

    task automatic tick;
        @(posedge HCLK);
        #1;
    endtask

    task automatic smp;
        @(negedge HCLK);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic addr_phase(input logic w, input logic [7:0] a,
                              input logic [2:0] s);
        HSEL   = 1'b1;
        HTRANS = 2'b10;
        HWRITE = w;
        HADDR  = a;
        HSIZE  = s;
    endtask

    task automatic idle_bus;
        HSEL   = 1'b0;
        HTRANS = 2'b00;
        HWRITE = 1'b0;
    endtask

    initial begin
        HRESET = 1'b1;
        HSEL = 0; HADDR = 0; HTRANS = 0; HWRITE = 0;
        HSIZE = 0; HBURST = 0; HWDATA = 0;
        tx_full = 0; rx_data = 0; rx_empty = 1;

        tick; tick; smp;
        chk("rst_hready", 64'(HREADYOUT), 64'd1);
        chk("rst_hresp", 64'(HRESP), 64'd0);
        chk("rst_hrdata", 64'(HRDATA), 64'd0);
        chk("rst_wr_en", 64'(tx_wr_en), 64'd0);
        chk("rst_rd_en", 64'(rx_rd_en), 64'd0);
        tick;
        HRESET = 1'b0;

        // byte write, lane 3
        addr_phase(1'b1, 8'h13, 3'd0);
        tick;
        idle_bus;
        HWDATA = 32'hAABBCCDD;
        p0 = push_cnt;
        smp;
        chk("bw_hready", 64'(HREADYOUT), 64'd1);
        chk("bw_wr_en", 64'(tx_wr_en), 64'd1);
        chk("bw_tx_data", 64'(tx_data), 64'h113_0000_00AA);
        tick;
        chk("bw_push", 64'(push_cnt - p0), 64'd1);
        smp;
        chk("bw_idle_wr_en", 64'(tx_wr_en), 64'd0);

        // write stalled by a full Tx FIFO
        addr_phase(1'b1, 8'h04, 3'd2);
        tick;
        idle_bus;
        HWDATA = 32'h11223344;
        tx_full = 1'b1;
        p0 = push_cnt;
        for (int i = 0; i < 3; i++) begin
            smp;
            chk($sformatf("stall_hready%0d", i), 64'(HREADYOUT), 64'd0);
            tick;
        end
        chk("stall_no_push", 64'(push_cnt - p0), 64'd0);
        tx_full = 1'b0;
        smp;
        chk("stall_wr_en", 64'(tx_wr_en), 64'd1);
        chk("stall_tx_data", 64'(tx_data), 64'h104_1122_3344);
        tick;
        chk("stall_push", 64'(push_cnt - p0), 64'd1);
        tick;
        chk("stall_nodup", 64'(push_cnt - p0), 64'd1);

        // word read
        addr_phase(1'b0, 8'h20, 3'd2);
        tick;
        idle_bus;
        p0 = push_cnt;
        q0 = pop_cnt;
        smp;
        chk("rd_cmd_wr_en", 64'(tx_wr_en), 64'd1);
        chk("rd_cmd_tx_data", 64'(tx_data), 64'h020_0000_0000);
        chk("rd_cmd_hready", 64'(HREADYOUT), 64'd0);
        tick;
        for (int i = 0; i < 4; i++) begin
            smp;
            chk($sformatf("rd_wait_hready%0d", i), 64'(HREADYOUT), 64'd0);
            tick;
        end
        rx_empty = 1'b0;
        rx_data = 32'h12345678;
        smp;
        chk("rd_pop_en", 64'(rx_rd_en), 64'd1);
        tick;
        rx_empty = 1'b1;
        rx_data = 32'h0;
        smp;
        chk("rd_hready", 64'(HREADYOUT), 64'd1);
        chk("rd_hresp", 64'(HRESP), 64'd0);
        chk("rd_hrdata", 64'(HRDATA), 64'h1234_5678);
        chk("rd_pop", 64'(pop_cnt - q0), 64'd1);
        chk("rd_push", 64'(push_cnt - p0), 64'd1);
        tick;
        smp;
        chk("rd_hold", 64'(HRDATA), 64'h1234_5678);

        // misaligned word access
        p0 = push_cnt;
        q0 = pop_cnt;
        addr_phase(1'b1, 8'h02, 3'd2);
        tick;
        idle_bus;
        smp;
        chk("err1_hresp", 64'(HRESP), 64'd1);
        chk("err1_hready", 64'(HREADYOUT), 64'd0);
        chk("err1_wr_en", 64'(tx_wr_en), 64'd0);
        tick;
        smp;
        chk("err2_hresp", 64'(HRESP), 64'd1);
        chk("err2_hready", 64'(HREADYOUT), 64'd1);
        tick;
        smp;
        chk("err_end_hresp", 64'(HRESP), 64'd0);
        chk("err_push", 64'(push_cnt - p0), 64'd0);
        chk("err_pop", 64'(pop_cnt - q0), 64'd0);

        // oversize access
        addr_phase(1'b0, 8'h00, 3'd3);
        tick;
        idle_bus;
        smp;
        chk("ovs_hresp", 64'(HRESP), 64'd1);
        chk("ovs_hready", 64'(HREADYOUT), 64'd0);
        tick;
        tick;

        // back-to-back writes, second a halfword on lane 2
        p0 = push_cnt;
        addr_phase(1'b1, 8'h08, 3'd2);
        tick;
        addr_phase(1'b1, 8'h0A, 3'd1);
        HWDATA = 32'hCAFEBABE;
        smp;
        chk("b2b1_hready", 64'(HREADYOUT), 64'd1);
        chk("b2b1_tx_data", 64'(tx_data), 64'h108_CAFE_BABE);
        tick;
        idle_bus;
        HWDATA = 32'h55667788;
        smp;
        chk("b2b2_hready", 64'(HREADYOUT), 64'd1);
        chk("b2b2_tx_data", 64'(tx_data), 64'h10A_0000_5566);
        tick;
        chk("b2b_push", 64'(push_cnt - p0), 64'd2);

        // unselected transfer
        p0 = push_cnt;
        addr_phase(1'b1, 8'h10, 3'd2);
        HSEL = 1'b0;
        tick;
        idle_bus;
        smp;
        chk("nsel_wr_en", 64'(tx_wr_en), 64'd0);
        chk("nsel_hready", 64'(HREADYOUT), 64'd1);
        tick;
        chk("nsel_push", 64'(push_cnt - p0), 64'd0);

        // reset during a stalled read command
        p0 = push_cnt;
        addr_phase(1'b0, 8'h30, 3'd2);
        tick;
        idle_bus;
        tx_full = 1'b1;
        smp;
        chk("mid_hready_lo", 64'(HREADYOUT), 64'd0);
        tick;
        HRESET = 1'b1;
        tx_full = 1'b0;
        smp;
        chk("mid_rst_wr_en", 64'(tx_wr_en), 64'd0);
        tick;
        HRESET = 1'b0;
        smp;
        chk("mid_hready", 64'(HREADYOUT), 64'd1);
        chk("mid_hrdata", 64'(HRDATA), 64'd0);
        chk("mid_push", 64'(push_cnt - p0), 64'd0);

`ifdef AHB_SPI_RD_TIMEOUT_EN
        // read with no Rx data ever arriving
        q0 = pop_cnt;
        addr_phase(1'b0, 8'h40, 3'd2);
        tick;
        idle_bus;
        rx_empty = 1'b1;
        tick;
        for (int i = 0; i < 8; i++) begin
            smp;
            chk($sformatf("to_wait_hresp%0d", i), 64'(HRESP), 64'd0);
            tick;
        end
        smp;
        chk("to_err1_hresp", 64'(HRESP), 64'd1);
        chk("to_err1_hready", 64'(HREADYOUT), 64'd0);
        tick;
        smp;
        chk("to_err2_hresp", 64'(HRESP), 64'd1);
        chk("to_err2_hready", 64'(HREADYOUT), 64'd1);
        chk("to_pop", 64'(pop_cnt - q0), 64'd0);
`endif

        tick;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
